// File: rtl/tdm_pkg.sv
// Shared definitions for the 16:1 TDM link: frame geometry defaults and the
// receive-side alignment state encoding.
package tdm_pkg;

  localparam int NCH_DEF = 16;
  localparam int SW_DEF  = 4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux16_if.sv
// Link-side bundle of the TDM receiver: serial beat inputs and the parallel
// frame / status outputs. The slave modport is the receiver's view.
interface tdm_demux16_if #(
  parameter int NCH = tdm_pkg::NCH_DEF,
  parameter int SW  = tdm_pkg::SW_DEF
);

  logic           din;
  logic           din_valid;
  logic           frame_sync;
  logic [NCH-1:0] dout;
  logic           dout_valid;
  logic [SW-1:0]  slot;
  logic           locked;
  logic           sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter shared by both ends of the TDM link; clear has
// priority over load-to-1, which has priority over increment.
module tdm_slot_ctr #(
  parameter int SW = tdm_pkg::SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load1_i,
  input  logic          inc_i,
  output logic [SW-1:0] slot_o
);

  logic [SW-1:0] slot_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (clr_i) begin
      slot_q <= '0;
    end else if (load1_i) begin
      slot_q <= SW'(1);
    end else if (inc_i) begin
      slot_q <= slot_q + SW'(1);
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux16.sv
// TDM receiver: acquires frame alignment from frame_sync, shifts serial slots
// into a shadow word and publishes each complete frame for one cycle.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int NCH          = NCH_DEF,
  parameter int SW           = SW_DEF,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  tdm_demux16_if.slave bus
);

  state_e         state_q;
  logic [NCH-1:0] shadow_q;
  logic [NCH-1:0] dout_q;
  logic           dout_valid_q;
  logic           sync_err_q;
  logic [SW-1:0]  slot;

  logic beat;
  logic at_zero;
  logic at_last;
  logic ctr_clr;
  logic ctr_load;
  logic ctr_inc;

  assign beat    = bus.din_valid;
  assign at_zero = (slot == '0);
  assign at_last = (slot == SW'(NCH - 1));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    if (beat) begin
      case (state_q)
        HUNT: ctr_load = bus.frame_sync;
        LOCK: begin
          if (bus.frame_sync)              ctr_load = 1'b1;
          else if (at_zero && REQUIRE_SYNC) ctr_clr  = 1'b1;
          else                              ctr_inc  = 1'b1;
        end
        default: ctr_clr = 1'b1;
      endcase
    end
  end

  tdm_slot_ctr #(.SW(SW)) u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load),
    .inc_i   (ctr_inc),
    .slot_o  (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (beat) begin
        case (state_q)
          HUNT: begin
            if (bus.frame_sync) begin
              shadow_q <= NCH'(bus.din);
              state_q  <= LOCK;
            end
          end
          LOCK: begin
            if (bus.frame_sync) begin
              // Early sync drops the partial frame and restarts from a clean word.
              if (!at_zero) begin
                sync_err_q <= 1'b1;
                shadow_q   <= NCH'(bus.din);
              end else begin
                shadow_q[0] <= bus.din;
              end
            end else if (at_zero && REQUIRE_SYNC) begin
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
            end else begin
              shadow_q[slot] <= bus.din;
              if (at_last) begin
                dout_q       <= {bus.din, shadow_q[NCH-2:0]};
                dout_valid_q <= 1'b1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot;
  assign bus.locked     = (state_q == LOCK);
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: completed frames are queued as stimulus is
// driven and popped by a monitor whenever the receiver publishes a frame.
module tb_tdm_demux16;

  logic clk;
  logic rst;

  tdm_demux16_if #(.NCH(16), .SW(4)) bus ();

  tdm_demux16 #(.NCH(16), .SW(4), .REQUIRE_SYNC(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pushes      = 0;
  int sync_seen   = 0;
  int exp_sync    = 0;

  logic [15:0] sb[$];
  int          pulse_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every published frame must match the oldest queued one.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      check("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("sb_dout", 32'(bus.dout), 32'(sb.pop_front()));
    end
    if (bus.sync_err === 1'b1) sync_seen++;
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic beat(input logic d, input logic fs);
    bus.din        = d;
    bus.frame_sync = fs;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] word, input int from);
    for (int i = from; i < 16; i++) begin
      if (i == 15) begin
        sb.push_back(word);
        pushes++;
      end
      beat(word[i], i == 0);
    end
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    int          base;

    rst            = 1'b1;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    #2;
    check("rst_dout",       32'(bus.dout),       32'h0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_sync_err",   32'(bus.sync_err),   32'h0);
    check("rst_locked",     32'(bus.locked),     32'h0);
    check("rst_slot",       32'(bus.slot),       32'h0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, LSB first.
    send_bits(16'hA5C3, 0);
    check("t1_dout_valid", 32'(bus.dout_valid), 32'h1);
    check("t1_dout",       32'(bus.dout),       32'hA5C3);
    check("t1_locked",     32'(bus.locked),     32'h1);
    check("t1_slot",       32'(bus.slot),       32'h0);
    idle(1);
    check("t1_pulse_end",  32'(bus.dout_valid), 32'h0);
    check("t1_hold",       32'(bus.dout),       32'hA5C3);

    // Beats before sync are discarded while hunting.
    do_reset();
    base = sync_seen;
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    check("t2_hunt_slot",   32'(bus.slot),   32'h0);
    check("t2_hunt_locked", 32'(bus.locked), 32'h0);
    send_bits(16'h0001, 0);
    check("t2_dout", 32'(bus.dout), 32'h0001);
    idle(1);
    check("t2_no_sync_err", 32'(sync_seen - base), 32'h0);

    // Back-to-back frames with din_valid held high.
    pulse_cyc.delete();
    send_bits(16'hFFFF, 0);
    send_bits(16'h0000, 0);
    send_bits(16'h8001, 0);
    idle(1);
    check("t3_pulses", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      check("t3_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);
      check("t3_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd16);
    end
    check("t3_dout", 32'(bus.dout), 32'h8001);

    // Idle cycles interleaved with beats leave the slot untouched.
    w = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        sb.push_back(w);
        pushes++;
      end
      beat(w[i], i == 0);
      check("t4_slot_beat", 32'(bus.slot), 32'((i + 1) % 16));
      idle(1);
      check("t4_slot_idle", 32'(bus.slot), 32'((i + 1) % 16));
    end
    check("t4_dout", 32'(bus.dout), 32'h1234);

    // Early sync at slot 7 realigns onto the 16'h00F0 frame.
    w = 16'hFFFF;
    for (int i = 0; i < 7; i++) beat(w[i], i == 0);
    check("t5_slot7", 32'(bus.slot), 32'd7);
    w = 16'h00F0;
    beat(w[0], 1'b1);
    exp_sync++;
    check("t5_sync_err",  32'(bus.sync_err),   32'h1);
    check("t5_no_frame",  32'(bus.dout_valid), 32'h0);
    check("t5_realigned", 32'(bus.slot),       32'h1);
    send_bits(w, 1);
    check("t5_dout", 32'(bus.dout), 32'h00F0);
    idle(1);
    check("t5_sync_err_end", 32'(bus.sync_err), 32'h0);

    // Missing sync on slot 0 drops lock.
    beat(1'b1, 1'b0);
    exp_sync++;
    check("t5_miss_sync_err", 32'(bus.sync_err), 32'h1);
    check("t5_miss_locked",   32'(bus.locked),   32'h0);
    check("t5_miss_slot",     32'(bus.slot),     32'h0);
    idle(2);

    // Asynchronous reset in the middle of a frame.
    w = 16'hFFFF;
    for (int i = 0; i < 9; i++) beat(w[i], i == 0);
    check("t6_slot9", 32'(bus.slot), 32'd9);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_dout",   32'(bus.dout),   32'h0);
    check("t6_rst_slot",   32'(bus.slot),   32'h0);
    check("t6_rst_locked", 32'(bus.locked), 32'h0);
    check("t6_rst_dv",     32'(bus.dout_valid), 32'h0);
    bus.din_valid = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_bits(16'h5A5A, 0);
    check("t6_dout", 32'(bus.dout), 32'h5A5A);
    idle(2);

    check("sb_drained",   32'(sb.size()),   32'h0);
    check("sync_err_cnt", 32'(sync_seen),   32'(exp_sync));
    check("frame_cnt",    32'(pushes),      32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
